// File: rtl/tournament_branch_predictor.sv
// Tournament branch predictor: gshare and bimodal 2-bit tables arbitrated by a per-PC chooser,
// with a speculative global history register that is repaired on a resolved mispredict.
module tournament_branch_predictor #(
    parameter int ADDR_WIDTH     = 32,
    parameter int IDX_BITS       = 10,
    parameter int G_HISTORY_BITS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      dec_valid,
    input  logic                      dec_is_jump,
    input  logic [ADDR_WIDTH-1:0]     dec_pc,
    input  logic [ADDR_WIDTH-1:0]     dec_target,
    input  logic                      dec_advance,
    output logic                      prediction,
    output logic                      prediction_gshare,
    output logic                      prediction_2bit,
    output logic [ADDR_WIDTH-1:0]     recovery_target,
    output logic [G_HISTORY_BITS-1:0] ghistory,
    input  logic                      res_valid,
    input  logic [ADDR_WIDTH-1:0]     res_pc,
    input  logic                      res_outcome,
    input  logic                      res_prediction,
    input  logic                      res_prediction_gshare,
    input  logic                      res_prediction_2bit,
    input  logic [G_HISTORY_BITS-1:0] res_ghistory,
    output logic                      ready,
    output logic [31:0]               branch_count,
    output logic [31:0]               mispredict_count
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [1:0] CTR_WEAK_NT     = 2'b01;
    localparam logic [1:0] CHOOSE_WEAK_GSH = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] SKIP_BYTES = ADDR_WIDTH'(4'd8);

    logic [0:0]                state_r;
    logic [IDX_BITS-1:0]       init_ptr_r;
    logic [G_HISTORY_BITS-1:0] ghr_r;
    logic [31:0]               branch_count_r;
    logic [31:0]               mispredict_count_r;
    logic [1:0]                bimodal_r [ENTRIES];
    logic [1:0]                gshare_r  [ENTRIES];
    logic [1:0]                chooser_r [ENTRIES];

    logic                      running_s;
    logic [IDX_BITS-1:0]       dec_pidx_s;
    logic [IDX_BITS-1:0]       dec_gidx_s;
    logic                      pred_s;
    logic                      pred_gshare_s;
    logic                      pred_2bit_s;
    logic [ADDR_WIDTH-1:0]     recovery_s;
    logic [IDX_BITS-1:0]       res_pidx_s;
    logic [IDX_BITS-1:0]       res_gidx_s;
    logic                      res_fire_s;
    logic                      res_miss_s;
    logic                      spec_shift_s;
    logic                      bim_we_s;
    logic [IDX_BITS-1:0]       bim_addr_s;
    logic [1:0]                bim_data_s;
    logic                      gsh_we_s;
    logic [IDX_BITS-1:0]       gsh_addr_s;
    logic [1:0]                gsh_data_s;
    logic                      cho_we_s;
    logic [IDX_BITS-1:0]       cho_addr_s;
    logic [1:0]                cho_data_s;
    logic                      unused_bits_s;

    // Two-bit saturating counter step: up toward 3 or down toward 0.
    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
        logic [1:0] nxt;
        if (up) begin
            nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return nxt;
    endfunction

    // Gshare index: history folds into the low bits of the PC index (history never wider than index).
    function automatic logic [IDX_BITS-1:0] hash_idx(input logic [IDX_BITS-1:0] pidx,
                                                     input logic [G_HISTORY_BITS-1:0] hist);
        logic [IDX_BITS-1:0] h;
        h = pidx;
        h[G_HISTORY_BITS-1:0] = pidx[G_HISTORY_BITS-1:0] ^ hist;
        return h;
    endfunction

    assign running_s     = (state_r == ST_RUN);
    assign dec_pidx_s    = dec_pc[IDX_BITS+1:2];
    assign dec_gidx_s    = hash_idx(dec_pidx_s, ghr_r);
    assign res_pidx_s    = res_pc[IDX_BITS+1:2];
    assign res_gidx_s    = hash_idx(res_pidx_s, res_ghistory);
    assign res_fire_s    = running_s & res_valid;
    assign res_miss_s    = res_fire_s & (res_prediction != res_outcome);
    assign spec_shift_s  = running_s & dec_valid & dec_advance & ~dec_is_jump;
    assign unused_bits_s = ^{res_pc[1:0], res_pc[ADDR_WIDTH-1:IDX_BITS+2],
                             res_ghistory[G_HISTORY_BITS-1]};

    // Zero-latency lookup; predictions are forced low while initialising or with no branch in decode.
    always_comb begin
        pred_s        = 1'b0;
        pred_gshare_s = 1'b0;
        pred_2bit_s   = 1'b0;
        if (running_s && dec_valid) begin
            pred_2bit_s   = bimodal_r[dec_pidx_s][1];
            pred_gshare_s = gshare_r[dec_gidx_s][1];
            if (dec_is_jump) begin
                pred_s = 1'b1;
            end else begin
                pred_s = chooser_r[dec_pidx_s][1] ? pred_gshare_s : pred_2bit_s;
            end
        end else begin
            pred_s = 1'b0;
        end
        // A taken prediction falls back to the fall-through past the delay slot.
        recovery_s = pred_s ? (dec_pc + SKIP_BYTES) : dec_target;
    end

    // Table write ports: initialisation sweep, otherwise training from the resolution stream.
    always_comb begin
        bim_we_s   = 1'b0;
        bim_addr_s = res_pidx_s;
        bim_data_s = sat_step(bimodal_r[res_pidx_s], res_outcome);
        gsh_we_s   = 1'b0;
        gsh_addr_s = res_gidx_s;
        gsh_data_s = sat_step(gshare_r[res_gidx_s], res_outcome);
        cho_we_s   = 1'b0;
        cho_addr_s = res_pidx_s;
        cho_data_s = sat_step(chooser_r[res_pidx_s], res_prediction_gshare == res_outcome);
        if (rst) begin
            bim_we_s = 1'b0;
            gsh_we_s = 1'b0;
            cho_we_s = 1'b0;
        end else if (!running_s) begin
            bim_we_s   = 1'b1;
            bim_addr_s = init_ptr_r;
            bim_data_s = CTR_WEAK_NT;
            gsh_we_s   = 1'b1;
            gsh_addr_s = init_ptr_r;
            gsh_data_s = CTR_WEAK_NT;
            cho_we_s   = 1'b1;
            cho_addr_s = init_ptr_r;
            cho_data_s = CHOOSE_WEAK_GSH;
        end else if (res_fire_s) begin
            bim_we_s = 1'b1;
            gsh_we_s = 1'b1;
            cho_we_s = (res_prediction_gshare != res_prediction_2bit);
        end else begin
            bim_we_s = 1'b0;
            gsh_we_s = 1'b0;
            cho_we_s = 1'b0;
        end
    end

    // Counter tables; no reset because the INIT sweep defines every entry.
    always_ff @(posedge clk) begin
        if (bim_we_s) bimodal_r[bim_addr_s] <= bim_data_s;
        if (gsh_we_s) gshare_r[gsh_addr_s]  <= gsh_data_s;
        if (cho_we_s) chooser_r[cho_addr_s] <= cho_data_s;
    end

    // INIT/RUN sequencing with the table sweep pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_INIT;
            init_ptr_r <= '0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    init_ptr_r <= init_ptr_r + IDX_BITS'(1'b1);
                    if (init_ptr_r == {IDX_BITS{1'b1}}) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN:  state_r <= ST_RUN;
                default: begin
                    state_r    <= ST_INIT;
                    init_ptr_r <= '0;
                end
            endcase
        end
    end

    // Speculative history; a mispredict repair wins because the decode slot is being flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_r <= '0;
        end else if (res_miss_s) begin
            ghr_r <= {res_ghistory[G_HISTORY_BITS-2:0], res_outcome};
        end else if (spec_shift_s) begin
            ghr_r <= {ghr_r[G_HISTORY_BITS-2:0], pred_s};
        end
    end

    // Resolution statistics, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count_r     <= 32'd0;
            mispredict_count_r <= 32'd0;
        end else if (res_fire_s) begin
            branch_count_r <= branch_count_r + 32'd1;
            if (res_miss_s) begin
                mispredict_count_r <= mispredict_count_r + 32'd1;
            end
        end
    end

    assign prediction        = pred_s;
    assign prediction_gshare = pred_gshare_s;
    assign prediction_2bit   = pred_2bit_s;
    assign recovery_target   = recovery_s;
    assign ghistory          = ghr_r;
    assign ready             = running_s;
    assign branch_count      = branch_count_r;
    assign mispredict_count  = mispredict_count_r;

endmodule

// File: tb/tb_tournament_branch_predictor.sv
// Directed bench for tournament_branch_predictor (IDX_BITS=4, G_HISTORY_BITS=4); expectations are
// queued with the stimulus and checked by an independent monitor on the falling edge.
module tb_tournament_branch_predictor;

    localparam int AW = 32;
    localparam int IB = 4;
    localparam int GB = 4;

    localparam int F_READY = 0;
    localparam int F_PRED  = 1;
    localparam int F_PG    = 2;
    localparam int F_P2    = 3;
    localparam int F_RT    = 4;
    localparam int F_GH    = 5;
    localparam int F_BC    = 6;
    localparam int F_MC    = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          dec_valid, dec_is_jump, dec_advance;
    logic [AW-1:0] dec_pc, dec_target;
    logic          prediction, prediction_gshare, prediction_2bit;
    logic [AW-1:0] recovery_target;
    logic [GB-1:0] ghistory;
    logic          res_valid, res_outcome, res_prediction, res_prediction_gshare, res_prediction_2bit;
    logic [AW-1:0] res_pc;
    logic [GB-1:0] res_ghistory;
    logic          ready;
    logic [31:0]   branch_count, mispredict_count;

    typedef struct {
        string       nm;
        int          fld;
        logic [31:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    tournament_branch_predictor #(.ADDR_WIDTH(AW), .IDX_BITS(IB), .G_HISTORY_BITS(GB)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_is_jump(dec_is_jump), .dec_pc(dec_pc),
        .dec_target(dec_target), .dec_advance(dec_advance),
        .prediction(prediction), .prediction_gshare(prediction_gshare),
        .prediction_2bit(prediction_2bit), .recovery_target(recovery_target),
        .ghistory(ghistory),
        .res_valid(res_valid), .res_pc(res_pc), .res_outcome(res_outcome),
        .res_prediction(res_prediction), .res_prediction_gshare(res_prediction_gshare),
        .res_prediction_2bit(res_prediction_2bit), .res_ghistory(res_ghistory),
        .ready(ready), .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_field(input string nm, input int fld, input logic [31:0] v);
        exp_t e;
        e.nm  = nm;
        e.fld = fld;
        e.v   = v;
        q.push_back(e);
    endtask

    task automatic set_res(input logic v, input logic [AW-1:0] pc, input logic outc,
                           input logic rp, input logic rpg, input logic rp2,
                           input logic [GB-1:0] gh);
        res_valid             = v;
        res_pc                = pc;
        res_outcome           = outc;
        res_prediction        = rp;
        res_prediction_gshare = rpg;
        res_prediction_2bit   = rp2;
        res_ghistory          = gh;
    endtask

    task automatic set_dec(input logic v, input logic j, input logic adv,
                           input logic [AW-1:0] pc, input logic [AW-1:0] tgt);
        dec_valid   = v;
        dec_is_jump = j;
        dec_advance = adv;
        dec_pc      = pc;
        dec_target  = tgt;
    endtask

    // Monitor: drains every expectation queued for this cycle, away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e = q.pop_front();
                case (e.fld)
                    F_READY: act = {31'd0, ready};
                    F_PRED:  act = {31'd0, prediction};
                    F_PG:    act = {31'd0, prediction_gshare};
                    F_P2:    act = {31'd0, prediction_2bit};
                    F_RT:    act = recovery_target;
                    F_GH:    act = {{(32-GB){1'b0}}, ghistory};
                    F_BC:    act = branch_count;
                    F_MC:    act = mispredict_count;
                    default: act = 32'hxxxx_xxxx;
                endcase
                checks++;
                if (act !== e.v) begin
                    errors++;
                    $display("FAIL %s got 0x%0h want 0x%0h", e.nm, act, e.v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        set_dec(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_res(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        repeat (3) cyc();

        // Reset state
        set_dec(1'b1, 1'b0, 1'b0, 32'h40, 32'h1234);
        expect_field("rst_ready", F_READY, 32'd0);
        expect_field("rst_pred", F_PRED, 32'd0);
        expect_field("rst_pg", F_PG, 32'd0);
        expect_field("rst_p2", F_P2, 32'd0);
        expect_field("rst_rt", F_RT, 32'h1234);
        expect_field("rst_gh", F_GH, 32'd0);
        expect_field("rst_bc", F_BC, 32'd0);
        expect_field("rst_mc", F_MC, 32'd0);
        rst = 1'b0;
        for (int i = 1; i < 16; i++) begin
            cyc();
            expect_field($sformatf("init_ready_%0d", i), F_READY, 32'd0);
            expect_field($sformatf("init_pred_%0d", i), F_PRED, 32'd0);
        end
        cyc();
        expect_field("ready_rise", F_READY, 32'd1);
        expect_field("first_pred", F_PRED, 32'd0);
        expect_field("first_pg", F_PG, 32'd0);
        expect_field("first_p2", F_P2, 32'd0);
        expect_field("first_gh", F_GH, 32'd0);
        expect_field("first_rt", F_RT, 32'h1234);

        // pc 0x40 trained taken: counters 01 -> 10 -> 11, then capped, then one not-taken
        set_res(1'b1, 32'h40, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
        cyc();
        expect_field("train1_bc", F_BC, 32'd1);
        expect_field("train1_mc", F_MC, 32'd0);
        expect_field("train1_p2", F_P2, 32'd1);
        expect_field("train1_pg", F_PG, 32'd1);
        expect_field("train1_pred", F_PRED, 32'd1);
        expect_field("train1_rt", F_RT, 32'h48);
        cyc();
        expect_field("train2_bc", F_BC, 32'd2);
        expect_field("train2_p2", F_P2, 32'd1);
        expect_field("train2_rt", F_RT, 32'h48);
        cyc();
        expect_field("train3_bc", F_BC, 32'd3);
        set_res(1'b1, 32'h40, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
        cyc();
        set_res(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        expect_field("sat_bc", F_BC, 32'd4);
        expect_field("sat_mc", F_MC, 32'd1);
        expect_field("sat_gh", F_GH, 32'd0);

        // Unconditional jump
        set_dec(1'b1, 1'b1, 1'b1, 32'h100, 32'h200);
        expect_field("sat_p2", F_P2, 32'd1);
        expect_field("sat_pg", F_PG, 32'd1);
        expect_field("jump_pred", F_PRED, 32'd1);
        expect_field("jump_rt", F_RT, 32'h108);
        cyc();
        set_dec(1'b0, 1'b0, 1'b0, 32'h40, 32'h200);
        expect_field("jump_gh_hold", F_GH, 32'd0);
        expect_field("novalid_pred", F_PRED, 32'd0);
        expect_field("novalid_pg", F_PG, 32'd0);
        expect_field("novalid_p2", F_P2, 32'd0);

        // Mispredict repair loads history 0x7
        set_res(1'b1, 32'h84, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3);
        cyc();
        set_res(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        set_dec(1'b1, 1'b0, 1'b1, 32'h1C, 32'h500);
        expect_field("repair_gh", F_GH, 32'h7);
        expect_field("repair_bc", F_BC, 32'd5);
        expect_field("repair_mc", F_MC, 32'd2);
        expect_field("hist7_pred", F_PRED, 32'd1);
        expect_field("hist7_pg", F_PG, 32'd1);
        expect_field("hist7_p2", F_P2, 32'd0);
        expect_field("hist7_rt", F_RT, 32'h24);
        cyc();

        // Speculative shift, then a same-cycle mispredict overrides the next shift
        set_dec(1'b1, 1'b0, 1'b1, 32'h3C, 32'h500);
        expect_field("spec_gh", F_GH, 32'hF);
        expect_field("histF_pred", F_PRED, 32'd1);
        expect_field("histF_pg", F_PG, 32'd1);
        expect_field("histF_p2", F_P2, 32'd0);
        expect_field("histF_rt", F_RT, 32'h44);
        set_res(1'b1, 32'hC0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h3);
        cyc();
        set_dec(1'b1, 1'b0, 1'b0, 32'h40, 32'h1234);
        expect_field("prio_gh", F_GH, 32'h6);
        expect_field("prio_bc", F_BC, 32'd6);
        expect_field("prio_mc", F_MC, 32'd3);
        expect_field("untrain_p2", F_P2, 32'd0);
        expect_field("untrain_pred", F_PRED, 32'd0);
        expect_field("untrain_rt", F_RT, 32'h1234);

        // Chooser at pidx 5: gshare right twice (10->11->11), bimodal right twice (11->10->01)
        set_res(1'b1, 32'h14, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        set_dec(1'b1, 1'b0, 1'b0, 32'h14, 32'h1234);
        cyc();
        expect_field("cho_a_pred", F_PRED, 32'd0);
        expect_field("cho_a_pg", F_PG, 32'd0);
        expect_field("cho_a_p2", F_P2, 32'd1);
        expect_field("cho_a_bc", F_BC, 32'd7);
        cyc();
        expect_field("cho_b_pred", F_PRED, 32'd0);
        expect_field("cho_b_p2", F_P2, 32'd1);
        expect_field("cho_b_bc", F_BC, 32'd8);
        set_res(1'b1, 32'h14, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
        cyc();
        expect_field("cho_c_pred", F_PRED, 32'd0);
        expect_field("cho_c_pg", F_PG, 32'd0);
        expect_field("cho_c_p2", F_P2, 32'd1);
        expect_field("cho_c_bc", F_BC, 32'd9);
        expect_field("cho_c_mc", F_MC, 32'd3);
        cyc();
        set_res(1'b0, 32'h14, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
        expect_field("cho_d_pred", F_PRED, 32'd1);
        expect_field("cho_d_pg", F_PG, 32'd0);
        expect_field("cho_d_p2", F_P2, 32'd1);
        expect_field("cho_d_rt", F_RT, 32'h1C);
        expect_field("cho_d_bc", F_BC, 32'd10);
        expect_field("cho_d_gh", F_GH, 32'h6);

        // Reset again, then a second reset at init_ptr=7 restarts the full sweep
        rst = 1'b1;
        cyc();
        expect_field("rst2_ready", F_READY, 32'd0);
        expect_field("rst2_bc", F_BC, 32'd0);
        expect_field("rst2_mc", F_MC, 32'd0);
        expect_field("rst2_gh", F_GH, 32'd0);
        expect_field("rst2_pred", F_PRED, 32'd0);
        expect_field("rst2_rt", F_RT, 32'h1234);
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            cyc();
            expect_field($sformatf("mid_ready_%0d", i), F_READY, 32'd0);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        expect_field("restart_ready", F_READY, 32'd0);
        set_res(1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 1'b1, 4'h5);
        for (int i = 1; i < 16; i++) begin
            cyc();
            expect_field($sformatf("reinit_ready_%0d", i), F_READY, 32'd0);
        end
        cyc();
        expect_field("reready", F_READY, 32'd1);
        expect_field("reready_bc", F_BC, 32'd0);
        expect_field("reready_mc", F_MC, 32'd0);
        expect_field("reready_gh", F_GH, 32'd0);
        expect_field("reready_pred", F_PRED, 32'd0);
        expect_field("reready_pg", F_PG, 32'd0);
        expect_field("reready_p2", F_P2, 32'd0);
        set_res(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        cyc();
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
